// File: rtl/led_breath_ctrl.sv
// Multi-channel LED brightness engine: a triangle ramp with programmable hold at both
// ends feeds one first-order sigma-delta modulator per LED channel.
module led_breath_ctrl #(
    parameter int NUM_CH     = 8,
    parameter int PWM_BITS   = 6,
    parameter int RAMP_SHIFT = 20,
    parameter int HOLD_TICKS = 0,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                CLK50M,
    input  logic                RESET_N,
    input  logic [1:0]          MODE,
    input  logic [PWM_BITS-1:0] LEVEL,
    output logic [NUM_CH-1:0]   LED,
    output logic [PWM_BITS-1:0] RAMP_LEVEL,
    output logic                PEAK,
    output logic [1:0]          fsm_state
);

    localparam int HOLD_W    = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam int HOLD_LAST = (HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0;
    localparam logic [HOLD_W-1:0]   HOLD_END = HOLD_W'(HOLD_LAST);
    localparam logic [PWM_BITS-1:0] MAX_LVL  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] LVL_ONE  = PWM_BITS'(1);
    localparam logic                LED_OFF  = (ACTIVE_LOW != 0);

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_STATIC = 2'b01;
    localparam logic [1:0] MODE_INPH   = 2'b10;

    typedef enum logic [1:0] {
        ST_UP      = 2'b00,
        ST_HOLD_HI = 2'b01,
        ST_DN      = 2'b10,
        ST_HOLD_LO = 2'b11
    } state_t;

    state_t                state;
    logic [1:0]            mode_q;
    logic [RAMP_SHIFT-1:0] prescaler;
    logic [HOLD_W-1:0]     hold_cnt;
    logic                  tick;
    logic                  restart;

    logic [PWM_BITS-1:0] lvl_d [NUM_CH];
    logic [PWM_BITS-1:0] lvl_q [NUM_CH];
    logic [PWM_BITS-1:0] acc   [NUM_CH];
    logic [PWM_BITS:0]   sum   [NUM_CH];

    // A new mode is registered and the whole engine restarts on the same edge.
    assign restart   = (MODE != mode_q);
    assign tick      = &prescaler;
    assign fsm_state = state;

    always_ff @(posedge CLK50M or negedge RESET_N) begin
        if (!RESET_N) begin
            mode_q     <= MODE_OFF;
            prescaler  <= '0;
            hold_cnt   <= '0;
            state      <= ST_UP;
            RAMP_LEVEL <= '0;
            PEAK       <= 1'b0;
        end else begin
            mode_q <= MODE;
            PEAK   <= 1'b0;
            if (restart) begin
                prescaler  <= '0;
                hold_cnt   <= '0;
                state      <= ST_UP;
                RAMP_LEVEL <= '0;
            end else begin
                prescaler <= prescaler + RAMP_SHIFT'(1);
                if (tick) begin
                    case (state)
                        ST_UP: begin
                            RAMP_LEVEL <= RAMP_LEVEL + LVL_ONE;
                            if (RAMP_LEVEL == MAX_LVL - LVL_ONE) begin
                                PEAK  <= 1'b1;
                                state <= (HOLD_TICKS == 0) ? ST_DN : ST_HOLD_HI;
                            end
                        end
                        ST_HOLD_HI: begin
                            if (hold_cnt == HOLD_END) begin
                                hold_cnt <= '0;
                                state    <= ST_DN;
                            end else begin
                                hold_cnt <= hold_cnt + HOLD_W'(1);
                            end
                        end
                        ST_DN: begin
                            RAMP_LEVEL <= RAMP_LEVEL - LVL_ONE;
                            if (RAMP_LEVEL == LVL_ONE) begin
                                state <= (HOLD_TICKS == 0) ? ST_UP : ST_HOLD_LO;
                            end
                        end
                        ST_HOLD_LO: begin
                            if (hold_cnt == HOLD_END) begin
                                hold_cnt <= '0;
                                state    <= ST_UP;
                            end else begin
                                hold_cnt <= hold_cnt + HOLD_W'(1);
                            end
                        end
                        default: state <= ST_UP;
                    endcase
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            lvl_d[i] = '0;
            case (mode_q)
                MODE_OFF:    lvl_d[i] = '0;
                MODE_STATIC: lvl_d[i] = LEVEL;
                MODE_INPH:   lvl_d[i] = RAMP_LEVEL;
                default:     lvl_d[i] = ((i % 2) != 0) ? ~RAMP_LEVEL : RAMP_LEVEL;
            endcase
            sum[i] = {1'b0, acc[i]} + {1'b0, lvl_q[i]};
        end
    end

    // The carry out of the accumulator is the modulated bit for each channel.
    always_ff @(posedge CLK50M or negedge RESET_N) begin
        if (!RESET_N) begin
            LED <= {NUM_CH{LED_OFF}};
            for (int i = 0; i < NUM_CH; i++) begin
                lvl_q[i] <= '0;
                acc[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                lvl_q[i] <= lvl_d[i];
                acc[i]   <= (restart || mode_q == MODE_OFF) ? '0 : sum[i][PWM_BITS-1:0];
                LED[i]   <= sum[i][PWM_BITS] ^ LED_OFF;
            end
        end
    end

endmodule

// File: tb/tb_led_breath_ctrl.sv
// Bench for led_breath_ctrl: an active-high and an active-low instance share all
// inputs and are compared every cycle against a closed-form ramp/duty model.
module tb_led_breath_ctrl;

  localparam int NCH = 8;
  localparam int P   = 6;
  localparam int S   = 2;
  localparam int H   = 2;
  localparam int M   = (1 << P) - 1;
  localparam int TP  = 1 << S;
  localparam int PT  = 2 * (M + H);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [P-1:0] level = '0;

  logic [NCH-1:0] led_o, led_inv;
  logic [P-1:0]   ramp_o, ramp_inv;
  logic           peak_o, peak_inv;
  logic [1:0]     state_o, state_inv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_breath_ctrl #(.NUM_CH(NCH), .PWM_BITS(P), .RAMP_SHIFT(S), .HOLD_TICKS(H), .ACTIVE_LOW(0)) dut (
    .CLK50M(clk), .RESET_N(rst_n), .MODE(mode), .LEVEL(level),
    .LED(led_o), .RAMP_LEVEL(ramp_o), .PEAK(peak_o), .fsm_state(state_o)
  );

  led_breath_ctrl #(.NUM_CH(NCH), .PWM_BITS(P), .RAMP_SHIFT(S), .HOLD_TICKS(H), .ACTIVE_LOW(1)) dut_inv (
    .CLK50M(clk), .RESET_N(rst_n), .MODE(mode), .LEVEL(level),
    .LED(led_inv), .RAMP_LEVEL(ramp_inv), .PEAK(peak_inv), .fsm_state(state_inv)
  );

  // Reference: ramp level as a function of ticks since restart, LED as the carry of
  // the running brightness total since the accumulators were last cleared.
  function automatic int ramp_at(int ticks);
    int r;
    r = ticks % PT;
    if (r <= M) return r;
    else if (r <= M + H) return M;
    else if (r <= 2 * M + H) return 2 * M + H - r;
    else return 0;
  endfunction

  function automatic int level_for(logic [1:0] md, int lv, int rp, int c);
    case (md)
      2'b00:   return 0;
      2'b01:   return lv;
      2'b10:   return rp;
      default: return ((c % 2) != 0) ? M - rp : rp;
    endcase
  endfunction

  int           m_n;
  logic [1:0]   m_mode;
  int           m_sum [NCH];
  int           m_lvl [NCH];
  int           m_next;
  logic         m_restart;
  logic [NCH-1:0] exp_led;
  int           exp_ramp;
  logic         exp_peak;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n = 0; m_mode = 2'b00; exp_led = '0; exp_ramp = 0; exp_peak = 1'b0;
      for (int c = 0; c < NCH; c++) begin m_sum[c] = 0; m_lvl[c] = 0; end
    end else begin
      m_restart = (mode != m_mode);
      for (int c = 0; c < NCH; c++) begin
        m_next = level_for(m_mode, int'(level), exp_ramp, c);
        exp_led[c] = ((m_sum[c] + m_lvl[c]) / (M + 1)) != (m_sum[c] / (M + 1));
        m_sum[c] = (m_restart || m_mode == 2'b00) ? 0 : m_sum[c] + m_lvl[c];
        m_lvl[c] = m_next;
      end
      if (m_restart) begin
        m_n = 0; exp_ramp = 0; exp_peak = 1'b0;
      end else begin
        m_n++;
        exp_ramp = ramp_at(m_n / TP);
        exp_peak = (m_n % TP == 0) && ((m_n / TP) % PT == M);
      end
      m_mode = mode;
    end
  end

  wire [2*NCH+2*P+1:0] obs_vec = {led_o, led_inv, ramp_o, ramp_inv, peak_o, peak_inv};
  wire [2*NCH+2*P+1:0] exp_vec = {exp_led, ~exp_led, P'(exp_ramp), P'(exp_ramp), exp_peak, exp_peak};
  wire [2*NCH+2*P+1:0] rst_vec = {{NCH{1'b0}}, {NCH{1'b1}}, {P{1'b0}}, {P{1'b0}}, 1'b0, 1'b0};

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (obs_vec !== rst_vec) begin errors++; $display("FAIL reset_init: got %h expected %h", obs_vec, rst_vec); end
    rst_n = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL reset_idle j=%0d: got %h expected %h", j, obs_vec, exp_vec); end
    end
  endtask

  task automatic test_static();
    int lv[$];
    int ones[NCH];
    lv = {32, 0, 63};
    repeat (3) lv.push_back($urandom_range(1, M - 1));
    foreach (lv[t]) begin
      mode = 2'b00;
      repeat (3) @(negedge clk);
      mode = 2'b01; level = P'(lv[t]);
      for (int c = 0; c < NCH; c++) ones[c] = 0;
      for (int j = 1; j <= 70; j++) begin
        @(negedge clk);
        checks++;
        if (obs_vec !== exp_vec) begin errors++; $display("FAIL static L=%0d j=%0d: got %h expected %h", lv[t], j, obs_vec, exp_vec); end
        if (j >= 3 && j <= 66) for (int c = 0; c < NCH; c++) ones[c] += int'(led_o[c]);
      end
      for (int c = 0; c < NCH; c++) begin
        checks++;
        if (ones[c] !== lv[t]) begin errors++; $display("FAIL static_duty ch%0d: got %0d ones expected %0d", c, ones[c], lv[t]); end
      end
    end
  endtask

  task automatic test_level_change();
    int l1, l2, ones;
    l1 = $urandom_range(0, M); l2 = $urandom_range(0, M);
    if (l2 == l1) l2 = M - l1;
    mode = 2'b01; level = P'(l1);
    for (int j = 1; j <= 70; j++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL level_pre j=%0d: got %h expected %h", j, obs_vec, exp_vec); end
    end
    level = P'(l2); ones = 0;
    for (int j = 1; j <= 70; j++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL level_post j=%0d: got %h expected %h", j, obs_vec, exp_vec); end
      if (j >= 2 && j <= 65) ones += int'(led_o[3]);
    end
    checks++;
    if (ones !== l2) begin errors++; $display("FAIL level_latency: got %0d ones expected %0d", ones, l2); end
  endtask

  task automatic test_off();
    int hits;
    mode = 2'b01; level = P'(M);
    repeat (70) @(negedge clk);
    mode = 2'b00; hits = 0;
    for (int j = 1; j <= 70; j++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL off j=%0d: got %h expected %h", j, obs_vec, exp_vec); end
      if (j >= 2 && led_o != '0) hits++;
    end
    checks++;
    if (hits !== 0) begin errors++; $display("FAIL off_dark: got %0d lit cycles expected 0", hits); end
  endtask

  task automatic test_breathe();
    int last_peak, peaks;
    mode = 2'b00;
    repeat (3) @(negedge clk);
    mode = 2'b10; last_peak = -1; peaks = 0;
    for (int j = 1; j <= 1100; j++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL breathe j=%0d: got %h expected %h", j, obs_vec, exp_vec); end
      if (peak_o) begin
        checks++;
        if (ramp_o !== P'(M)) begin errors++; $display("FAIL peak_level: got %0d expected %0d", ramp_o, M); end
        if (last_peak >= 0) begin
          checks++;
          if (j - last_peak !== PT * TP) begin errors++; $display("FAIL peak_period: got %0d expected %0d", j - last_peak, PT * TP); end
        end
        last_peak = j; peaks++;
      end
    end
    checks++;
    if (peaks !== 2) begin errors++; $display("FAIL peak_count: got %0d expected 2", peaks); end
  endtask

  task automatic test_anti_phase();
    mode = 2'b00;
    repeat (3) @(negedge clk);
    mode = 2'b11;
    for (int j = 1; j <= 600; j++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL anti j=%0d: got %h expected %h", j, obs_vec, exp_vec); end
    end
  endtask

  task automatic test_mode_change();
    bit found;
    mode = 2'b10; found = 1'b0;
    for (int j = 1; j <= 400 && !found; j++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL mc_pre j=%0d: got %h expected %h", j, obs_vec, exp_vec); end
      if (ramp_o == P'(5)) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL mc_wait: got no RAMP_LEVEL=5 within 400 cycles expected one"); end
    mode = 2'b11;
    @(negedge clk);
    checks++;
    if (ramp_o !== '0) begin errors++; $display("FAIL mc_restart: got %0d expected 0", ramp_o); end
    for (int j = 1; j <= 200; j++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL mc_post j=%0d: got %h expected %h", j, obs_vec, exp_vec); end
    end
  endtask

  task automatic test_random();
    for (int j = 1; j <= 1500; j++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL random j=%0d mode=%0d: got %h expected %h", j, mode, obs_vec, exp_vec); end
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) level = P'($urandom_range(0, M));
    end
  endtask

  task automatic test_reset_mid();
    mode = 2'b10;
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs_vec !== rst_vec) begin errors++; $display("FAIL reset_mid: got %h expected %h", obs_vec, rst_vec); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL reset_resume j=%0d: got %h expected %h", j, obs_vec, exp_vec); end
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_level_change();
    test_off();
    test_breathe();
    test_anti_phase();
    test_mode_change();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
